// File: rtl/wb_stage_reg.sv
// M/W pipeline register with load extraction, write-back selection and a
// retired-instruction counter for the 5-stage MIPS core.
module wb_stage_reg #(
  parameter int          PC_W        = 32,
  parameter int          ADDR_W      = 5,
  parameter int          CNT_W       = 32,
  parameter int          LINK_OFFSET = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              m_valid_i,
  input  logic [31:0]       m_mem_data_i,
  input  logic [31:0]       m_alu_result_i,
  input  logic [PC_W-1:0]   m_pc_i,
  input  logic [31:0]       m_instr_i,
  input  logic              m_reg_write_i,
  input  logic [ADDR_W-1:0] m_a3_i,
  input  logic [1:0]        m_wd_sel_i,
  input  logic [2:0]        m_load_type_i,
  input  logic [1:0]        m_addr_lo_i,
  output logic              w_valid_o,
  output logic              w_reg_write_o,
  output logic [ADDR_W-1:0] w_a3_o,
  output logic [31:0]       w_wd_o,
  output logic [PC_W-1:0]   w_pc_o,
  output logic [31:0]       w_instr_o,
  output logic [CNT_W-1:0]  w_retired_o
);

  localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_LINK = PC_W'(LINK_OFFSET);

  logic              valid_q;
  logic [31:0]       mem_data_q;
  logic [31:0]       alu_result_q;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       instr_q;
  logic              reg_write_q;
  logic [ADDR_W-1:0] a3_q;
  logic [1:0]        wd_sel_q;
  logic [2:0]        load_type_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  retired_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      valid_q      <= 1'b0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      pc_q         <= PC_RST;
      instr_q      <= '0;
      reg_write_q  <= 1'b0;
      a3_q         <= '0;
      wd_sel_q     <= '0;
      load_type_q  <= '0;
      addr_lo_q    <= '0;
    end else if (!stall_i) begin
      valid_q      <= m_valid_i;
      mem_data_q   <= m_mem_data_i;
      alu_result_q <= m_alu_result_i;
      pc_q         <= m_pc_i;
      instr_q      <= m_instr_i;
      reg_write_q  <= m_reg_write_i;
      a3_q         <= m_a3_i;
      wd_sel_q     <= m_wd_sel_i;
      load_type_q  <= m_load_type_i;
      addr_lo_q    <= m_addr_lo_i;
    end
  end

  // Flush leaves the count alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (!flush_i && !stall_i && m_valid_i) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [31:0]     load_val;
  logic [PC_W-1:0] link_pc;
  logic [31:0]     link_wd;

  assign load_byte = mem_data_q[8*addr_lo_q +: 8];
  assign load_half = addr_lo_q[1] ? mem_data_q[31:16] : mem_data_q[15:0];
  assign link_pc   = pc_q + PC_LINK;
  assign link_wd   = 32'(link_pc);

  always_comb begin
    load_val = mem_data_q;
    case (load_type_q)
      3'd1:    load_val = {24'b0, load_byte};
      3'd2:    load_val = {{24{load_byte[7]}}, load_byte};
      3'd3:    load_val = {16'b0, load_half};
      3'd4:    load_val = {{16{load_half[15]}}, load_half};
      default: load_val = mem_data_q;
    endcase
  end

  always_comb begin
    w_wd_o = '0;
    case (wd_sel_q)
      2'd0:    w_wd_o = load_val;
      2'd1:    w_wd_o = alu_result_q;
      2'd2:    w_wd_o = link_wd;
      default: w_wd_o = '0;
    endcase
  end

  assign w_valid_o     = valid_q;
  assign w_reg_write_o = valid_q & reg_write_q & (a3_q != '0);
  assign w_a3_o        = a3_q;
  assign w_pc_o        = pc_q;
  assign w_instr_o     = instr_q;
  assign w_retired_o   = retired_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Scoreboard bench for wb_stage_reg: driver pushes reference-model results,
// a negedge monitor pops and compares; a CNT_W=4 copy checks counter wrap.
module tb_wb_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, m_valid_i, m_reg_write_i;
  logic [31:0] m_mem_data_i, m_alu_result_i, m_pc_i, m_instr_i;
  logic [4:0]  m_a3_i;
  logic [1:0]  m_wd_sel_i, m_addr_lo_i;
  logic [2:0]  m_load_type_i;

  logic        w_valid_o, w_reg_write_o;
  logic [4:0]  w_a3_o;
  logic [31:0] w_wd_o, w_pc_o, w_instr_o, w_retired_o;

  logic        c4_valid, c4_reg_write;
  logic [4:0]  c4_a3;
  logic [31:0] c4_wd, c4_pc, c4_instr;
  logic [3:0]  c4_retired;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_stage_reg dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .m_valid_i(m_valid_i), .m_mem_data_i(m_mem_data_i), .m_alu_result_i(m_alu_result_i),
    .m_pc_i(m_pc_i), .m_instr_i(m_instr_i), .m_reg_write_i(m_reg_write_i),
    .m_a3_i(m_a3_i), .m_wd_sel_i(m_wd_sel_i), .m_load_type_i(m_load_type_i),
    .m_addr_lo_i(m_addr_lo_i), .w_valid_o(w_valid_o), .w_reg_write_o(w_reg_write_o),
    .w_a3_o(w_a3_o), .w_wd_o(w_wd_o), .w_pc_o(w_pc_o), .w_instr_o(w_instr_o),
    .w_retired_o(w_retired_o)
  );

  wb_stage_reg #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .m_valid_i(m_valid_i), .m_mem_data_i(m_mem_data_i), .m_alu_result_i(m_alu_result_i),
    .m_pc_i(m_pc_i), .m_instr_i(m_instr_i), .m_reg_write_i(m_reg_write_i),
    .m_a3_i(m_a3_i), .m_wd_sel_i(m_wd_sel_i), .m_load_type_i(m_load_type_i),
    .m_addr_lo_i(m_addr_lo_i), .w_valid_o(c4_valid), .w_reg_write_o(c4_reg_write),
    .w_a3_o(c4_a3), .w_wd_o(c4_wd), .w_pc_o(c4_pc), .w_instr_o(c4_instr),
    .w_retired_o(c4_retired)
  );

  typedef struct {
    logic        valid;
    logic        reg_write;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
  } exp_t;

  exp_t        sb[$];
  exp_t        model;
  int unsigned retired_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_wd(input logic [31:0] mem, input logic [31:0] alu,
                                         input logic [31:0] pc, input logic [1:0] sel,
                                         input logic [2:0] lt, input logic [1:0] lo);
    int unsigned b, h, v;
    b = (mem >> (8 * lo)) % 256;
    h = (mem >> (16 * (lo / 2))) % 65536;
    case (lt)
      3'd1:    v = b;
      3'd2:    v = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd3:    v = h;
      3'd4:    v = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      default: v = mem;
    endcase
    case (sel)
      2'd0:    return v;
      2'd1:    return alu;
      2'd2:    return pc + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    if (reset || flush_i) begin
      model.valid = 0; model.reg_write = 0; model.a3 = 0; model.wd = 0;
      model.pc = 32'h3000; model.instr = 0;
      if (reset) retired_count = 0;
    end else if (!stall_i) begin
      model.valid     = m_valid_i;
      model.reg_write = m_valid_i && m_reg_write_i && (m_a3_i != 0);
      model.a3        = m_a3_i;
      model.wd        = ref_wd(m_mem_data_i, m_alu_result_i, m_pc_i, m_wd_sel_i,
                               m_load_type_i, m_addr_lo_i);
      model.pc        = m_pc_i;
      model.instr     = m_instr_i;
      if (m_valid_i) retired_count++;
    end
    model.retired = retired_count;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    sb.push_back(model);
    #1;
  endtask

  task automatic set_m(input logic v, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [31:0] pc, input logic rw, input logic [4:0] a3,
                       input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] lo);
    m_valid_i = v; m_mem_data_i = mem; m_alu_result_i = alu; m_pc_i = pc;
    m_instr_i = $urandom; m_reg_write_i = rw; m_a3_i = a3; m_wd_sel_i = sel;
    m_load_type_i = lt; m_addr_lo_i = lo;
  endtask

  task automatic set_random();
    set_m($urandom_range(3, 0) != 0, $urandom, $urandom, $urandom, $urandom_range(1, 0),
          ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom), 2'($urandom),
          3'($urandom), 2'($urandom));
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("valid",     32'(w_valid_o),     32'(e.valid));
      chk("reg_write", 32'(w_reg_write_o), 32'(e.reg_write));
      chk("a3",        32'(w_a3_o),        32'(e.a3));
      chk("wd",        w_wd_o,             e.wd);
      chk("pc",        w_pc_o,             e.pc);
      chk("instr",     w_instr_o,          e.instr);
      chk("retired",   w_retired_o,        e.retired);
      chk("retired4",  32'(c4_retired),    e.retired % 16);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    retired_count = 0;
    model = '{default: '0};
    reset = 1; stall_i = 0; flush_i = 0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("reset_pc", w_pc_o, 32'h3000);
    chk("reset_retired", w_retired_o, 32'd0);
    reset = 0;

    for (int i = 0; i < 17; i++) begin
      set_m(1, $urandom, $urandom, 32'h3000 + 4 * i, 1, 5'd2, 2'd1, 3'd0, 2'd0);
      cyc();
    end
    chk("wrap_c4", 32'(c4_retired), 32'd1);
    chk("count_17", w_retired_o, 32'd17);

    set_m(1, 32'h80FF7F01, 0, 32'h3040, 1, 5'd8, 2'd0, 3'd2, 2'd3); cyc();
    chk("lb_wd", w_wd_o, 32'hFFFFFF80);
    chk("lb_rw", 32'(w_reg_write_o), 32'd1);
    set_m(1, 32'h80FF7F01, 0, 32'h3044, 1, 5'd8, 2'd0, 3'd1, 2'd2); cyc();
    chk("lbu_wd", w_wd_o, 32'h000000FF);
    set_m(1, 0, 0, 32'h3010, 1, 5'd31, 2'd2, 3'd0, 2'd0); cyc();
    chk("jal_wd", w_wd_o, 32'h3018);
    set_m(1, 0, 0, 32'h3010, 1, 5'd0, 2'd2, 3'd0, 2'd0); cyc();
    chk("jal_a3zero_rw", 32'(w_reg_write_o), 32'd0);
    chk("jal_a3zero_wd", w_wd_o, 32'h3018);

    set_m(1, 32'h1234, 0, 32'h3050, 1, 5'd5, 2'd0, 3'd0, 2'd0); cyc();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin set_random(); cyc(); end
    chk("stall_wd", w_wd_o, 32'h1234);
    chk("stall_retired", w_retired_o, 32'd22);
    stall_i = 0;
    set_m(1, 0, 32'hABCD, 32'h3054, 1, 5'd6, 2'd1, 3'd0, 2'd0); cyc();
    chk("release_retired", w_retired_o, 32'd23);

    stall_i = 1; flush_i = 1;
    set_m(1, 0, 32'h55, 32'h3058, 1, 5'd7, 2'd1, 3'd0, 2'd0); cyc();
    chk("flush_valid", 32'(w_valid_o), 32'd0);
    chk("flush_pc", w_pc_o, 32'h3000);
    chk("flush_retired", w_retired_o, 32'd23);
    stall_i = 0; flush_i = 0;

    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(63, 0) == 0);
      flush_i = ($urandom_range(7, 0) == 0);
      stall_i = ($urandom_range(3, 0) == 0);
      set_random();
      cyc();
    end
    reset = 0; flush_i = 0; stall_i = 0;
    set_m(0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage_reg.md
Name: wb_stage_reg

Overview:
Parametrised M/W pipeline register and write-back selector for the 5-stage MIPS core. It latches the memory-stage bundle and supports stall (hold), flush (bubble insertion) and a valid bit. At W it performs load byte/half extraction and sign/zero extension. It produces the GRF write port, the W-stage forwarding value and a retired-instruction counter.

Parameters:
PC_W, 32, width of PC and link value
ADDR_W, 5, register-file address width
CNT_W, 32, retired-instruction counter width
LINK_OFFSET, 8, added to the latched PC to form the link value (jal/jalr)
RESET_PC, 32'h0000_3000, reset/flush value of the latched PC (truncated to PC_W)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall_i  in  1  hold W register contents
flush_i  in  1  load a bubble into W
m_valid_i  in  1  M-stage entry is a real instruction
m_mem_data_i  in  32  raw DM read word
m_alu_result_i  in  32  ALU/MDU result
m_pc_i  in  PC_W  PC of the M-stage instruction
m_instr_i  in  32  instruction word
m_reg_write_i  in  1  instruction writes GRF
m_a3_i  in  ADDR_W  destination register
m_wd_sel_i  in  2  0=memory, 1=ALU result, 2=link, 3=zero
m_load_type_i  in  3  0=lw, 1=lbu, 2=lb, 3=lhu, 4=lh, others=lw
m_addr_lo_i  in  2  low address bits of the load
w_valid_o  out  1  W holds a valid instruction
w_reg_write_o  out  1  qualified GRF write enable
w_a3_o  out  ADDR_W  GRF write address
w_wd_o  out  32  GRF write data (also the forwarding value)
w_pc_o  out  PC_W  PC of the W instruction
w_instr_o  out  32  instruction word in W
w_retired_o  out  CNT_W  retired-instruction count

Behaviour:
- Update priority each posedge: reset > flush_i > stall_i > load.
- Reset: all fields 0 except PC=RESET_PC.
  - Output values: w_valid_o=0, w_reg_write_o=0, w_a3_o=0, w_wd_o=0, w_pc_o=RESET_PC, w_instr_o=0, w_retired_o=0.
- Flush: same field values as reset, except w_retired_o is held. flush_i together with stall_i is still a flush.
- Stall: every field and w_retired_o hold their values.
- Load: all fields take their m_* inputs. Latency is exactly 1 cycle from M inputs to W outputs.
- w_reg_write_o = valid & reg_write & (a3 != 0). It is combinational from the latched fields. An invalid entry never writes the GRF and never forwards, regardless of its latched reg_write.
- Load extraction (combinational from latched mem_data / addr_lo, little-endian):
  - byte = mem[8*addr_lo+7 : 8*addr_lo]
  - half = addr_lo[1] ? mem[31:16] : mem[15:0]; addr_lo[0] is ignored for halfwords.
  - lbu/lhu zero-extend; lb/lh sign-extend; lw and codes 5–7 pass the word unchanged.
- w_wd_o selection:
  - sel 0 = extracted load value
  - sel 1 = ALU result
  - sel 2 = pc + LINK_OFFSET, modulo 2^PC_W, zero-extended or truncated to 32 bits
  - sel 3 = 0
- w_wd_o is driven identically whether or not w_reg_write_o is asserted. Consumers must qualify it with w_reg_write_o.
- Retired counter:
  - Increments by 1 on each posedge where a valid entry is loaded (!reset & !flush_i & !stall_i & m_valid_i).
  - The new count is visible in the same cycle the entry appears on w_valid_o.
  - Wraps from 2^CNT_W−1 to 0.
  - Never increments on stall, flush or reset.
- No internal combinational path from stall_i/flush_i to any output.

Test Plan:
- Reset then idle → after reset high for 2 cycles: w_pc_o=0x3000, w_valid_o=0, w_reg_write_o=0, w_retired_o=0.
- Load lb with mem=0x80FF7F01, addr_lo=3, a3=8, sel=0, valid → next cycle w_wd_o=0xFFFFFF80, w_reg_write_o=1. Same with lbu, addr_lo=2 → w_wd_o=0x000000FF.
- jal, pc=0x3010, sel=2, a3=31 → w_wd_o=0x3018. Same with a3=0 → w_reg_write_o=0, w_wd_o still 0x3018.
- Stall 3 cycles holding lw result 0x1234 while M inputs change → outputs hold 0x1234 and w_retired_o unchanged. Release → next M entry loads and counter increments by 1.
- flush_i and stall_i both high with a valid M entry → next cycle w_valid_o=0, w_reg_write_o=0, w_pc_o=0x3000, w_retired_o held.
- CNT_W=4 with 17 consecutive valid loads → w_retired_o wraps 15→0 and ends at 1.
